// File: rtl/boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : boot_loader                                                 |
// | Description: UART frame receiver that loads the instruction memory,      |
// |              checks the XOR checksum, then releases the CPU.             |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module boot_loader #(
  parameter int unsigned ADDR_W  = 11,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_armed;
  logic              r_rd_prev;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [31:0]       r_wr_data, w_wr_data_nxt;
  logic [7:0]        r_n, w_n_nxt;
  logic [7:0]        r_word_cnt, w_word_cnt_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [1:0]        r_byte_idx, w_byte_idx_nxt;
  logic [15:0]       r_to_cnt, w_to_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic              w_pop;
  logic              w_in_frame;
  logic              w_timeout;

  // r_armed keeps the pop strobe low until the first edge after reset release
  assign w_pop      = r_armed && !rx_empty && !r_rd_prev && !r_wr_en && (r_state != DONE);
  assign w_in_frame = (r_state == COUNT) || (r_state == DATA) || (r_state == CSUM);
  assign w_timeout  = w_in_frame && (r_to_cnt == TIMEOUT) && !w_pop;

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_n_nxt        = r_n;
    w_word_cnt_nxt = r_word_cnt;
    w_csum_nxt     = r_csum;
    w_byte_idx_nxt = r_byte_idx;
    w_err_nxt      = r_err;

    if (w_pop || !w_in_frame) begin
      w_to_cnt_nxt = 16'd0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + 16'd1;
    end

    if (r_wr_en) begin
      w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (w_pop && (r_data == SYNC)) begin
          w_state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (w_pop) begin
          if (r_data == 8'd0) begin
            w_state_nxt = IDLE;
          end else begin
            w_n_nxt        = r_data;
            w_word_cnt_nxt = 8'd0;
            w_csum_nxt     = 8'd0;
            w_byte_idx_nxt = 2'd0;
            w_wr_addr_nxt  = '0;
            w_state_nxt    = DATA;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (w_pop) begin
          w_wr_data_nxt[{r_byte_idx, 3'b000} +: 8] = r_data;
          w_csum_nxt     = r_csum ^ r_data;
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_wr_en_nxt    = 1'b1;
            w_word_cnt_nxt = r_word_cnt + 8'd1;
          end
        end else if (r_wr_en && (r_word_cnt == r_n)) begin
          // last word is on the write port this cycle
          w_state_nxt = CSUM;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      CSUM: begin
        if (w_pop) begin
          if (r_data == r_csum) begin
            w_state_nxt = DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_rd_prev  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 32'd0;
      r_n        <= 8'd0;
      r_word_cnt <= 8'd0;
      r_csum     <= 8'd0;
      r_byte_idx <= 2'd0;
      r_to_cnt   <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_armed    <= 1'b1;
      r_rd_prev  <= w_pop;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_n        <= w_n_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_csum     <= w_csum_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign rd_uart  = w_pop;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign done     = (r_state == DONE);
  assign cpu_hold = (r_state != DONE);
  assign err      = r_err;

endmodule
`default_nettype wire
